// File: rtl/piso_pkg.sv
// Shared definitions for the PISO link scheduler: FSM state encoding and the
// serializer geometry the scheduler frames words for.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XMIT = 2'd2,
        GAP  = 2'd3
    } pisoState_e;

    localparam int PISO_WORD_W     = 32;
    localparam int PISO_BIT_CYCLES = 2;
    localparam int XMIT_CYCLES     = PISO_WORD_W * PISO_BIT_CYCLES;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first valid requester searching upward
// from the one after the most recent grant, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] lastGrant_i,
    output logic             grantValid_o,
    output logic [IDX_W-1:0] grantIdx_o,
    output logic [N_REQ-1:0] grantOneHot_o
);

    // Walk the candidates in priority order and keep only the first valid one.
    always_comb begin
        int cand;
        grantValid_o  = 1'b0;
        grantIdx_o    = '0;
        grantOneHot_o = '0;
        cand          = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(lastGrant_i) + k) % N_REQ;
            if (!grantValid_o && valid_i[cand]) begin
                grantValid_o = 1'b1;
                grantIdx_o   = IDX_W'(cand);
            end
        end
        if (grantValid_o) begin
            grantOneHot_o[grantIdx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/piso_sched.sv
// Round-robin scheduler that owns framing for a single parallel-in/serial-out
// link: accepts one word, strobes load, holds xmit for the full serial time,
// then enforces a quiet gap before the next grant.
module piso_sched import piso_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int WORD_W     = PISO_WORD_W,
    parameter int BIT_CYCLES = PISO_BIT_CYCLES,
    parameter int GAP_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*WORD_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      ser_load_o,
    output logic                      ser_xmit_o,
    output logic [WORD_W-1:0]         ser_data_o,
    output logic                      busy_o,
    output logic                      tx_done_o,
    output logic [$clog2(N_REQ)-1:0]  last_grant_o,
    output logic [15:0]               sent_count_o
);

    localparam int                IDX_W      = $clog2(N_REQ);
    localparam int                XMIT_LEN   = WORD_W * BIT_CYCLES;
    localparam int                XCNT_W     = $clog2(XMIT_LEN + 1);
    localparam logic [XCNT_W-1:0] XMIT_LAST  = XCNT_W'(XMIT_LEN - 1);
    localparam logic [7:0]        GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(N_REQ - 1);

    pisoState_e          state_q, state_d;
    logic [XCNT_W-1:0]   xcnt_q, xcnt_d;
    logic [7:0]          gapCnt_q, gapCnt_d;
    logic [IDX_W-1:0]    lastGrant_q, lastGrant_d;
    logic [WORD_W-1:0]   serData_q, serData_d;
    logic                txDone_d;
    logic                serLoad_q, serXmit_q, busy_q, txDone_q;
    logic [15:0]         sentCount_q;

    logic                grantValid;
    logic [IDX_W-1:0]    grantIdx;
    logic [N_REQ-1:0]    grantOneHot;
    logic                accept;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) uArbiter (
        .valid_i      (req_valid_i),
        .lastGrant_i  (lastGrant_q),
        .grantValid_o (grantValid),
        .grantIdx_o   (grantIdx),
        .grantOneHot_o(grantOneHot)
    );

    // A grant happens only from IDLE with enable high; ready is held low while in reset.
    assign accept      = (state_q == IDLE) && enable_i && grantValid;
    assign req_ready_o = (accept && rst) ? grantOneHot : '0;

    // Next-state logic: word capture in IDLE, fixed-length xmit count, then the gap.
    always_comb begin
        state_d     = state_q;
        xcnt_d      = xcnt_q;
        gapCnt_d    = gapCnt_q;
        lastGrant_d = lastGrant_q;
        serData_d   = serData_q;
        txDone_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = LOAD;
                    lastGrant_d = grantIdx;
                    serData_d   = req_data_i[grantIdx*WORD_W +: WORD_W];
                end
            end
            LOAD: begin
                state_d = XMIT;
                xcnt_d  = '0;
            end
            XMIT: begin
                if (xcnt_q == XMIT_LAST) begin
                    xcnt_d   = '0;
                    gapCnt_d = '0;
                    txDone_d = 1'b1;
                    state_d  = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    xcnt_d = xcnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    gapCnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the captured word; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            xcnt_q      <= '0;
            gapCnt_q    <= '0;
            lastGrant_q <= LAST_RESET;
            serData_q   <= '0;
        end else begin
            state_q     <= state_d;
            xcnt_q      <= xcnt_d;
            gapCnt_q    <= gapCnt_d;
            lastGrant_q <= lastGrant_d;
            serData_q   <= serData_d;
        end
    end

    // Serializer controls and status are decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serLoad_q   <= 1'b0;
            serXmit_q   <= 1'b0;
            busy_q      <= 1'b0;
            txDone_q    <= 1'b0;
            sentCount_q <= '0;
        end else begin
            serLoad_q <= (state_d == LOAD);
            serXmit_q <= (state_d == XMIT);
            busy_q    <= (state_d != IDLE);
            txDone_q  <= txDone_d;
            if (txDone_d) begin
                sentCount_q <= sentCount_q + 1'b1;
            end
        end
    end

    assign ser_load_o   = serLoad_q;
    assign ser_xmit_o   = serXmit_q;
    assign ser_data_o   = serData_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = txDone_q;
    assign last_grant_o = lastGrant_q;
    assign sent_count_o = sentCount_q;

endmodule

// File: tb/tb_piso_sched.sv
// Self-checking bench for piso_sched: one instance with the default gap and
// one with no gap, checked against a queue of expected grants and words.
module tb_piso_sched;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en0, en1;
    logic [3:0]   valid0, valid1;
    logic [127:0] data0, data1;
    logic [3:0]   ready0, ready1;
    logic         load0, load1, xmit0, xmit1, busy0, busy1, done0, done1;
    logic [31:0]  sdata0, sdata1;
    logic [1:0]   lastg0, lastg1;
    logic [15:0]  sent0, sent1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    piso_sched #(.N_REQ(4), .WORD_W(32), .BIT_CYCLES(2), .GAP_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .enable_i(en0), .req_valid_i(valid0), .req_data_i(data0),
        .req_ready_o(ready0), .ser_load_o(load0), .ser_xmit_o(xmit0), .ser_data_o(sdata0),
        .busy_o(busy0), .tx_done_o(done0), .last_grant_o(lastg0), .sent_count_o(sent0)
    );

    piso_sched #(.N_REQ(4), .WORD_W(32), .BIT_CYCLES(2), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .enable_i(en1), .req_valid_i(valid1), .req_data_i(data1),
        .req_ready_o(ready1), .ser_load_o(load1), .ser_xmit_o(xmit1), .ser_data_o(sdata1),
        .busy_o(busy1), .tx_done_o(done1), .last_grant_o(lastg1), .sent_count_o(sent1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0] rdy(input bit sel);
        return sel ? ready1 : ready0;
    endfunction

    function automatic logic ld(input bit sel);
        return sel ? load1 : load0;
    endfunction

    function automatic logic xm(input bit sel);
        return sel ? xmit1 : xmit0;
    endfunction

    function automatic logic dn(input bit sel);
        return sel ? done1 : done0;
    endfunction

    function automatic logic [31:0] sd(input bit sel);
        return sel ? sdata1 : sdata0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Follows one word from its grant to its tx_done, recording what the link saw.
    task automatic observeWord(input bit sel, input int dropAt,
                               output bit timedOut, output int acceptCyc, output int idx,
                               output int loadFirst, output int loadCnt,
                               output int xmitFirst, output int xmitCnt, output int doneOff,
                               output bit bothHigh, output logic [31:0] capWord,
                               output logic [31:0] dataAtLoad);
        int          n;
        int          off;
        logic [3:0]  rv;
        logic [31:0] w;
        timedOut   = 1'b0;
        acceptCyc  = -1;
        idx        = -1;
        loadFirst  = -1;
        loadCnt    = 0;
        xmitFirst  = -1;
        xmitCnt    = 0;
        doneOff    = -1;
        bothHigh   = 1'b0;
        capWord    = '0;
        dataAtLoad = '0;
        #1;
        n = 0;
        while (rdy(sel) == 4'b0 && n < 400) begin
            tick();
            n++;
        end
        rv = rdy(sel);
        if (rv == 4'b0) begin
            timedOut = 1'b1;
            return;
        end
        acceptCyc = cyc;
        if ($countones(rv) != 1) idx = -2;
        else for (int i = 0; i < 4; i++) if (rv[i]) idx = i;
        n = 0;
        while (doneOff < 0 && n < 200) begin
            tick();
            n++;
            off = cyc - acceptCyc;
            w   = sd(sel);
            if (ld(sel)) begin
                loadCnt++;
                if (loadFirst < 0) begin
                    loadFirst  = off;
                    dataAtLoad = w;
                end
            end
            if (xm(sel)) begin
                if (xmitFirst < 0) xmitFirst = off;
                if (xmitCnt % 2 == 1) capWord = {capWord[30:0], w[31 - xmitCnt/2]};
                xmitCnt++;
            end
            if (ld(sel) && xm(sel)) bothHigh = 1'b1;
            if (dn(sel)) doneOff = off;
            if (off == dropAt) begin
                if (sel) en1 = 1'b0;
                else     en0 = 1'b0;
            end
        end
        if (doneOff < 0) timedOut = 1'b1;
    endtask

    // Reset values of every registered output on both instances.
    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (load0 !== 1'b0 || xmit0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl: load=%b xmit=%b expected 0 0", load0, xmit0); end
        checks++; if (sdata0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", sdata0); end
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_status: busy=%b done=%b expected 0 0", busy0, done0); end
        checks++; if (sent0 !== 16'h0) begin errors++; $display("[TB] FAIL reset_sent: got %h expected 0", sent0); end
        checks++; if (lastg0 !== 2'd3 || lastg1 !== 2'd3) begin errors++; $display("[TB] FAIL reset_last_grant: got %0d/%0d expected 3", lastg0, lastg1); end
        rst = 1'b1;
        tick();
        checks++; if (busy0 !== 1'b0 || ready0 !== 4'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy=%b ready=%b expected 0 0000", busy0, ready0); end
    endtask

    // One word from requester 0: exact framing, serial content and counters.
    task automatic test_single_word();
        bit to; int acc, idx, lf, lc, xf, xc, dOff; bit both; logic [31:0] cap, dl;
        exp_t e;
        data0[31:0] = 32'hA5A5_00FF;
        valid0 = 4'b0001;
        expQ.push_back('{0, 32'hA5A5_00FF});
        observeWord(1'b0, -1, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
        valid0 = 4'b0000;
        e = expQ.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL single_timeout: timed out waiting for the word"); return; end
        checks++; if (idx !== e.idx) begin errors++; $display("[TB] FAIL single_grant: got %0d expected %0d", idx, e.idx); end
        checks++; if (lf !== 1 || lc !== 1) begin errors++; $display("[TB] FAIL single_load: first=%0d count=%0d expected 1 1", lf, lc); end
        checks++; if (xf !== 2 || xc !== 64) begin errors++; $display("[TB] FAIL single_xmit: first=%0d count=%0d expected 2 64", xf, xc); end
        checks++; if (dOff !== 66) begin errors++; $display("[TB] FAIL single_done: cycle %0d expected 66", dOff); end
        checks++; if (both !== 1'b0) begin errors++; $display("[TB] FAIL single_overlap: load and xmit high together"); end
        checks++; if (cap !== e.data || dl !== e.data) begin errors++; $display("[TB] FAIL single_serial: got %h/%h expected %h", cap, dl, e.data); end
        checks++; if (sent0 !== 16'd1) begin errors++; $display("[TB] FAIL single_sent: got %0d expected 1", sent0); end
        tick(); tick(); tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL single_gap_busy: got %b expected 1", busy0); end
        tick();
        checks++; if (busy0 !== 1'b0 || sdata0 !== e.data) begin errors++; $display("[TB] FAIL single_idle: busy=%b data=%h expected 0 %h", busy0, sdata0, e.data); end
    endtask

    // All requesters valid from reset: fair order and a fixed 70-cycle word period.
    task automatic test_round_robin();
        bit to; int acc, idx, lf, lc, xf, xc, dOff; bit both; logic [31:0] cap, dl;
        int prevAcc;
        exp_t e;
        logic [31:0] words [4] = '{32'h0F0F_0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        int order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b0;
        tick();
        rst = 1'b1;
        data0 = {words[3], words[2], words[1], words[0]};
        valid0 = 4'b1111;
        for (int k = 0; k < 5; k++) expQ.push_back('{order[k], words[order[k]]});
        prevAcc = -1;
        for (int k = 0; k < 5; k++) begin
            observeWord(1'b0, -1, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
            e = expQ.pop_front();
            checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL rr_timeout: word %0d timed out", k); return; end
            checks++; if (idx !== e.idx || cap !== e.data) begin errors++; $display("[TB] FAIL rr_word%0d: grant %0d data %h expected %0d %h", k, idx, cap, e.idx, e.data); end
            if (k > 0) begin
                checks++; if (acc - prevAcc !== 70) begin errors++; $display("[TB] FAIL rr_period%0d: got %0d expected 70", k, acc - prevAcc); end
            end
            prevAcc = acc;
        end
        checks++; if (sent0 !== 16'd5) begin errors++; $display("[TB] FAIL rr_sent: got %0d expected 5", sent0); end
    endtask

    // Enable dropped mid-xmit: the word and its gap finish, then grants stop until re-enabled.
    task automatic test_enable_drop();
        bit to; int acc, idx, lf, lc, xf, xc, dOff; bit both; logic [31:0] cap, dl;
        int bad;
        exp_t e;
        expQ.push_back('{1, 32'h1111_0001});
        observeWord(1'b0, 12, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
        e = expQ.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL en_timeout: word timed out"); return; end
        checks++; if (idx !== e.idx || xc !== 64 || dOff !== 66) begin errors++; $display("[TB] FAIL en_complete: grant %0d xmit %0d done %0d expected %0d 64 66", idx, xc, dOff, e.idx); end
        checks++; if (cap !== e.data) begin errors++; $display("[TB] FAIL en_data: got %h expected %h", cap, e.data); end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready0 !== 4'b0 || load0 !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL en_no_grant: %0d grant cycles expected 0", bad); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL en_idle: busy=%b expected 0", busy0); end
        en0 = 1'b1;
        expQ.push_back('{2, 32'h2222_0002});
        observeWord(1'b0, -1, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
        e = expQ.pop_front();
        checks++; if (to !== 1'b0 || idx !== e.idx || cap !== e.data) begin errors++; $display("[TB] FAIL en_resume: grant %0d data %h expected %0d %h", idx, cap, e.idx, e.data); end
    endtask

    // Asynchronous reset in xmit cycle 30: outputs clear at once, priority restarts at requester 0.
    task automatic test_reset_mid_xmit();
        bit to; int acc, idx, lf, lc, xf, xc, dOff; bit both; logic [31:0] cap, dl;
        int n;
        exp_t e;
        valid0 = 4'b0110;
        expQ.push_back('{1, 32'h1111_0001});
        #1;
        n = 0;
        while (ready0 == 4'b0 && n < 400) begin tick(); n++; end
        e = expQ.pop_front();
        checks++; if (ready0 !== 4'b0010) begin errors++; $display("[TB] FAIL rm_grant: ready %b expected %b", ready0, 4'b0010); return; end
        for (int i = 0; i < 32; i++) tick();
        checks++; if (xmit0 !== 1'b1 || sdata0 !== e.data) begin errors++; $display("[TB] FAIL rm_in_flight: xmit=%b data=%h expected 1 %h", xmit0, sdata0, e.data); end
        rst = 1'b0;
        #1;
        checks++; if (xmit0 !== 1'b0 || load0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL rm_async_ctrl: xmit=%b load=%b busy=%b done=%b expected 0", xmit0, load0, busy0, done0); end
        checks++; if (sdata0 !== 32'h0 || sent0 !== 16'h0 || lastg0 !== 2'd3) begin errors++; $display("[TB] FAIL rm_async_regs: data=%h sent=%0d last=%0d expected 0 0 3", sdata0, sent0, lastg0); end
        tick();
        tick();
        valid0 = 4'b1111;
        rst = 1'b1;
        expQ.push_back('{0, 32'h0F0F_0000});
        observeWord(1'b0, -1, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
        e = expQ.pop_front();
        checks++; if (to !== 1'b0 || idx !== e.idx || lf !== 1 || cap !== e.data) begin errors++; $display("[TB] FAIL rm_restart: grant %0d load %0d data %h expected %0d 1 %h", idx, lf, cap, e.idx, e.data); end
        valid0 = 4'b0000;
    endtask

    // No gap: words 66 cycles apart and the completed-word counter wraps.
    task automatic test_gap_zero();
        bit to; int acc, idx, lf, lc, xf, xc, dOff; bit both; logic [31:0] cap, dl;
        int prevAcc;
        exp_t e;
        force dut1.sentCount_q = 16'hFFFF;
        tick();
        release dut1.sentCount_q;
        tick();
        checks++; if (sent1 !== 16'hFFFF) begin errors++; $display("[TB] FAIL g0_preload: got %h expected ffff", sent1); end
        data1[95:64] = 32'hC0DE_0002;
        valid1 = 4'b0100;
        expQ.push_back('{2, 32'hC0DE_0002});
        expQ.push_back('{2, 32'hC0DE_0002});
        observeWord(1'b1, -1, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
        e = expQ.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL g0_timeout: first word timed out"); return; end
        checks++; if (idx !== e.idx || cap !== e.data || dOff !== 66) begin errors++; $display("[TB] FAIL g0_word0: grant %0d data %h done %0d expected %0d %h 66", idx, cap, dOff, e.idx, e.data); end
        checks++; if (sent1 !== 16'h0000) begin errors++; $display("[TB] FAIL g0_wrap: got %h expected 0000", sent1); end
        prevAcc = acc;
        observeWord(1'b1, -1, to, acc, idx, lf, lc, xf, xc, dOff, both, cap, dl);
        valid1 = 4'b0000;
        e = expQ.pop_front();
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL g0_timeout2: second word timed out"); return; end
        checks++; if (acc - prevAcc !== 66) begin errors++; $display("[TB] FAIL g0_period: got %0d expected 66", acc - prevAcc); end
        checks++; if (idx !== e.idx || cap !== e.data || both !== 1'b0) begin errors++; $display("[TB] FAIL g0_word1: grant %0d data %h overlap %b expected %0d %h 0", idx, cap, both, e.idx, e.data); end
        checks++; if (sent1 !== 16'h0001 || lastg1 !== 2'd2) begin errors++; $display("[TB] FAIL g0_after: sent %h last %0d expected 0001 2", sent1, lastg1); end
    endtask

    initial begin
        rst    = 1'b0;
        en0    = 1'b1;
        en1    = 1'b1;
        valid0 = '0;
        valid1 = '0;
        data0  = '0;
        data1  = '0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_enable_drop();
        test_reset_mid_xmit();
        test_gap_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
